// File: rtl/note_pkg.sv
// Shared definitions for the note scheduler: FSM states, lane count,
// chart-word layout and small arithmetic helpers.
package note_pkg;

  localparam int unsigned LANES   = 4;
  localparam int unsigned CHART_W = 12;

  // Chart word layout: {lane_mask, delay}
  localparam int unsigned MASK_MSB  = 11;
  localparam int unsigned MASK_LSB  = 8;
  localparam int unsigned DELAY_MSB = 7;
  localparam int unsigned DELAY_LSB = 0;

  // An all-zero word (no lanes, no delay) terminates the chart
  localparam logic [CHART_W-1:0] END_MARKER = '0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWait,
    StSpawn,
    StDrain,
    StDone
  } state_e;

  function automatic logic [2:0] popcount_lanes(input logic [LANES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // 16-bit add that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {9'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/note_slot.sv
// One falling-note slot: holds valid/lanes/y, moves on tick, clears hit
// lanes and retires itself at the screen bottom or when fully hit.
module note_slot
  import note_pkg::*;
#(
  parameter int unsigned Y_W     = 9,
  parameter int unsigned Y_SPAWN = 0,
  parameter int unsigned Y_END   = 480
) (
  input  logic             CLOCK_24,
  input  logic             reset,
  input  logic             tick,
  input  logic             spawn,
  input  logic [LANES-1:0] spawn_lanes,
  input  logic [LANES-1:0] clear_mask,
  output logic             valid,
  output logic [LANES-1:0] lanes,
  output logic [Y_W-1:0]   y,
  output logic [LANES-1:0] miss_lanes
);

  logic             valid_q, valid_d;
  logic [LANES-1:0] lanes_q, lanes_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [Y_W:0]     y_inc;
  logic [LANES-1:0] lanes_left;
  logic             at_end;

  // Next state: spawn, then hit clearing (applied before retirement), then movement
  always_comb begin
    y_inc      = {1'b0, y_q} + (Y_W + 1)'(1);
    lanes_left = lanes_q & ~clear_mask;
    at_end     = tick && (y_inc == (Y_W + 1)'(Y_END));
    valid_d    = valid_q;
    lanes_d    = lanes_q;
    y_d        = y_q;
    miss_lanes = '0;
    if (spawn) begin
      valid_d = 1'b1;
      lanes_d = spawn_lanes;
      y_d     = Y_W'(Y_SPAWN);
    end else if (valid_q) begin
      if (at_end) begin
        // Only lanes surviving this cycle's hits count as missed
        valid_d    = 1'b0;
        lanes_d    = '0;
        y_d        = '0;
        miss_lanes = lanes_left;
      end else if (lanes_left == '0) begin
        valid_d = 1'b0;
        lanes_d = '0;
        y_d     = '0;
      end else begin
        lanes_d = lanes_left;
        if (tick) begin
          y_d = y_inc[Y_W-1:0];
        end
      end
    end
  end

  // Slot state register
  always_ff @(posedge CLOCK_24) begin
    if (reset) begin
      valid_q <= 1'b0;
      lanes_q <= '0;
      y_q     <= '0;
    end else begin
      valid_q <= valid_d;
      lanes_q <= lanes_d;
      y_q     <= y_d;
    end
  end

  assign valid = valid_q;
  assign lanes = lanes_q;
  assign y     = y_q;

endmodule

// File: rtl/note_scheduler.sv
// Chart sequencer for the rhythm game: fetches notes from the chart ROM,
// allocates them to slots, moves slots on a prescaled tick and judges presses.
module note_scheduler
  import note_pkg::*;
#(
  parameter int unsigned N_SLOTS  = 8,
  parameter int unsigned TICK_DIV = 800000,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned Y_SPAWN  = 0,
  parameter int unsigned Y_HIT    = 440,
  parameter int unsigned HIT_WIN  = 8,
  parameter int unsigned Y_END    = 480,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic                     CLOCK_24,
  input  logic                     reset,
  input  logic                     start,
  output logic [ADDR_W-1:0]        chart_addr,
  input  logic [CHART_W-1:0]       chart_data,
  input  logic [LANES-1:0]         buttons,
  output logic [N_SLOTS-1:0]       slot_valid,
  output logic [LANES*N_SLOTS-1:0] slot_lanes,
  output logic [Y_W*N_SLOTS-1:0]   slot_y,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count,
  output logic                     hit_pulse,
  output logic                     miss_pulse,
  output logic                     busy
);

  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WIN_LO = (Y_HIT > HIT_WIN) ? (Y_HIT - HIT_WIN) : 0;
  localparam int unsigned WIN_HI = Y_HIT + HIT_WIN;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [LANES-1:0]               mask_q, mask_d;
  logic [7:0]                     delay_q, delay_d;
  logic [CNT_W-1:0]               cnt_q;
  logic                           tick;
  logic [LANES-1:0]               buttons_q;
  logic [15:0]                    hit_q, miss_q;
  logic                           hit_pulse_q, miss_pulse_q;
  logic                           clear_cnt;
  logic                           spawn_any;
  logic                           free_any;
  logic [N_SLOTS-1:0]             free_onehot;
  logic [N_SLOTS-1:0]             spawn_vec;
  logic [N_SLOTS-1:0]             in_win;
  logic [LANES-1:0]               press;
  logic [LANES-1:0]               hit_lanes;
  logic [N_SLOTS-1:0][LANES-1:0]  clear_mask;
  logic [N_SLOTS-1:0][LANES-1:0]  lanes_arr;
  logic [N_SLOTS-1:0][LANES-1:0]  miss_arr;
  logic [N_SLOTS-1:0][Y_W-1:0]    y_arr;
  logic [2:0]                     n_hit;
  logic [7:0]                     n_miss;

  assign busy = (state_q != StIdle) && (state_q != StDone);
  assign tick = busy && (cnt_q == CNT_W'(TICK_DIV - 1));

  // Movement prescaler, held at zero whenever playback is not running
  always_ff @(posedge CLOCK_24) begin
    if (reset || !busy || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Lowest-index free slot, from the slot state at the start of the cycle
  always_comb begin
    free_any    = 1'b0;
    free_onehot = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!slot_valid[i] && !free_any) begin
        free_any       = 1'b1;
        free_onehot[i] = 1'b1;
      end
    end
  end

  assign spawn_vec = spawn_any ? free_onehot : '0;

  // Playback FSM next-state
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    delay_d   = delay_q;
    spawn_any = 1'b0;
    clear_cnt = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StFetch;
          addr_d    = '0;
          clear_cnt = 1'b1;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        mask_d  = chart_data[MASK_MSB:MASK_LSB];
        delay_d = chart_data[DELAY_MSB:DELAY_LSB];
        state_d = (chart_data == END_MARKER) ? StDrain : StWait;
      end
      StWait: begin
        if (delay_q == 8'd0) begin
          state_d = StSpawn;
        end else if (tick) begin
          delay_d = delay_q - 8'd1;
        end
      end
      StSpawn: begin
        // Rest entries advance without taking a slot; notes stall until one is free
        if (mask_q == '0) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StFetch;
        end else if (free_any) begin
          spawn_any = 1'b1;
          addr_d    = addr_q + ADDR_W'(1);
          state_d   = StFetch;
        end
      end
      StDrain: begin
        if (slot_valid == '0) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and chart-entry registers
  always_ff @(posedge CLOCK_24) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      mask_q  <= '0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      delay_q <= delay_d;
    end
  end

  assign chart_addr = addr_q;

  // Judge: each rising lane goes to the lowest-index in-window slot holding it
  always_comb begin
    press      = buttons & ~buttons_q;
    clear_mask = '0;
    hit_lanes  = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (press[k] && !hit_lanes[k] && slot_valid[i] && lanes_arr[i][k] && in_win[i]) begin
          clear_mask[i][k] = 1'b1;
          hit_lanes[k]     = 1'b1;
        end
      end
    end
  end

  // Total lanes missed by slots retiring this cycle
  always_comb begin
    n_hit  = popcount_lanes(hit_lanes);
    n_miss = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      n_miss = n_miss + 8'(popcount_lanes(miss_arr[i]));
    end
  end

  // Score counters, pulses and the button history for edge detection
  always_ff @(posedge CLOCK_24) begin
    if (reset) begin
      hit_q        <= '0;
      miss_q       <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      buttons_q    <= '0;
    end else begin
      if (clear_cnt) begin
        hit_q  <= '0;
        miss_q <= '0;
      end else begin
        hit_q  <= sat_add16(hit_q, 8'(n_hit));
        miss_q <= sat_add16(miss_q, n_miss);
      end
      hit_pulse_q  <= (n_hit != '0);
      miss_pulse_q <= (n_miss != '0);
      buttons_q    <= buttons;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    note_slot #(
      .Y_W     (Y_W),
      .Y_SPAWN (Y_SPAWN),
      .Y_END   (Y_END)
    ) u_slot (
      .CLOCK_24    (CLOCK_24),
      .reset       (reset),
      .tick        (tick),
      .spawn       (spawn_vec[i]),
      .spawn_lanes (mask_q),
      .clear_mask  (clear_mask[i]),
      .valid       (slot_valid[i]),
      .lanes       (lanes_arr[i]),
      .y           (y_arr[i]),
      .miss_lanes  (miss_arr[i])
    );

    assign in_win[i] = ({1'b0, y_arr[i]} >= (Y_W + 1)'(WIN_LO)) &&
                       ({1'b0, y_arr[i]} <= (Y_W + 1)'(WIN_HI));
  end

  assign slot_lanes = lanes_arr;
  assign slot_y     = y_arr;

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler with a behavioural chart ROM.
module tb_note_scheduler;
  import note_pkg::*;

  localparam int unsigned N_SLOTS  = 8;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned ADDR_W   = 6;

  localparam int SEL_VALID = 0;
  localparam int SEL_Y0    = 1;
  localparam int SEL_BUSY  = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [ADDR_W-1:0]        chart_addr;
  logic [CHART_W-1:0]       chart_data;
  logic [LANES-1:0]         buttons;
  logic [N_SLOTS-1:0]       slot_valid;
  logic [LANES*N_SLOTS-1:0] slot_lanes;
  logic [Y_W*N_SLOTS-1:0]   slot_y;
  logic [15:0]              hit_count;
  logic [15:0]              miss_count;
  logic                     hit_pulse;
  logic                     miss_pulse;
  logic                     busy;

  logic [CHART_W-1:0] rom [64];

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned hit_pulses  = 0;
  int unsigned miss_pulses = 0;

  string       tag_q[$];
  logic [31:0] val_q[$];

  note_scheduler #(
    .N_SLOTS  (N_SLOTS),
    .TICK_DIV (TICK_DIV),
    .Y_W      (Y_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .CLOCK_24   (clk),
    .reset      (reset),
    .start      (start),
    .chart_addr (chart_addr),
    .chart_data (chart_data),
    .buttons    (buttons),
    .slot_valid (slot_valid),
    .slot_lanes (slot_lanes),
    .slot_y     (slot_y),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Synchronous chart ROM: data one cycle after address
  always @(posedge clk) chart_data <= rom[chart_addr];

  // Pulse monitor
  always @(negedge clk) begin
    if (hit_pulse) hit_pulses++;
    if (miss_pulse) miss_pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic sb_expect(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    if (val_q.size() == 0) begin
      check_eq("sb_underflow", 32'(val_q.size()), 32'd1);
    end else begin
      check_eq(tag_q.pop_front(), obs, val_q.pop_front());
    end
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      SEL_VALID: return 32'(slot_valid);
      SEL_Y0:    return 32'(slot_y[Y_W-1:0]);
      default:   return 32'(busy);
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic [31:0] want,
                          input int budget);
    int n;
    n = 0;
    while (probe(sel) !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, probe(sel), want);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [LANES-1:0] b);
    buttons = b;
    @(negedge clk);
  endtask

  initial begin
    int unsigned base;
    int          n;
    logic [31:0] last_y;

    for (int i = 0; i < 64; i++) rom[i] = '0;
    reset   = 1'b1;
    start   = 1'b0;
    buttons = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(slot_valid), 32'd0);
    check_eq("rst_lanes", 32'(slot_lanes), 32'd0);
    check_eq("rst_y", 32'(slot_y[31:0]), 32'd0);
    check_eq("rst_addr", 32'(chart_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_hits", 32'(hit_count), 32'd0);
    check_eq("rst_miss", 32'(miss_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single delayed note that falls through unhit
    rom[0] = {4'b0001, 8'd2};
    rom[1] = '0;
    base   = miss_pulses;
    sb_expect("spawn_y", 32'd0);
    sb_expect("spawn_lanes", 32'd1);
    sb_expect("spawn_addr", 32'd1);
    pulse_start();
    check_eq("busy_run", 32'(busy), 32'd1);
    repeat (6) @(negedge clk);
    check_eq("delay_hold", 32'(slot_valid), 32'd0);
    wait_for("spawn0", SEL_VALID, 32'h01, 100);
    sb_check(32'(slot_y[Y_W-1:0]));
    sb_check(32'(slot_lanes[3:0]));
    sb_check(32'(chart_addr));
    sb_expect("retire_valid", 32'd0);
    sb_expect("retire_miss", 32'd1);
    n      = 0;
    last_y = '0;
    while (slot_valid[0] && n < 3000) begin
      last_y = 32'(slot_y[Y_W-1:0]);
      @(negedge clk);
      n++;
    end
    sb_check(32'(slot_valid[0]));
    sb_check(32'(miss_count));
    check_eq("retire_last_y", last_y, 32'd479);
    wait_for("done1", SEL_BUSY, 32'd0, 20);
    check_eq("miss_pulses1", 32'(miss_pulses - base), 32'd1);
    check_eq("hits1", 32'(hit_count), 32'd0);

    // Hit inside the window, then a repeat press with nothing to hit
    pulse_start();
    check_eq("clr_miss", 32'(miss_count), 32'd0);
    wait_for("y435", SEL_Y0, 32'd435, 2500);
    sb_expect("hit_cnt", 32'd1);
    sb_expect("hit_retire", 32'd0);
    sb_expect("hit_pulse", 32'd1);
    press(4'b0001);
    sb_check(32'(hit_count));
    sb_check(32'(slot_valid[0]));
    sb_check(32'(hit_pulse));
    press(4'b0000);
    @(negedge clk);
    press(4'b0001);
    check_eq("repeat_hits", 32'(hit_count), 32'd1);
    check_eq("repeat_pulse", 32'(hit_pulse), 32'd0);
    press(4'b0000);
    wait_for("done2", SEL_BUSY, 32'd0, 20);
    check_eq("hit_no_miss", 32'(miss_count), 32'd0);

    // Window boundary: 431 outside, 432 inside
    pulse_start();
    wait_for("y431", SEL_Y0, 32'd431, 2500);
    sb_expect("early_hits", 32'd0);
    sb_expect("early_valid", 32'd1);
    press(4'b0001);
    sb_check(32'(hit_count));
    sb_check(32'(slot_valid[0]));
    press(4'b0000);
    @(negedge clk);
    wait_for("y432", SEL_Y0, 32'd432, 10);
    sb_expect("edge_hits", 32'd1);
    sb_expect("edge_valid", 32'd0);
    press(4'b0001);
    sb_check(32'(hit_count));
    sb_check(32'(slot_valid[0]));
    press(4'b0000);
    wait_for("done3", SEL_BUSY, 32'd0, 20);

    // Nine simultaneous-lane notes: fill all slots, stall, reuse slot 0
    for (int i = 0; i < 9; i++) rom[i] = {4'b1111, 8'd0};
    rom[9] = '0;
    pulse_start();
    wait_for("fill", SEL_VALID, 32'hFF, 200);
    repeat (8) @(negedge clk);
    check_eq("stall_valid", 32'(slot_valid), 32'hFF);
    check_eq("stall_addr", 32'(chart_addr), 32'd8);
    sb_expect("free0_miss", 32'd4);
    sb_expect("free0_addr", 32'd8);
    wait_for("free0", SEL_VALID, 32'hFE, 2500);
    sb_check(32'(miss_count));
    sb_check(32'(chart_addr));
    sb_expect("reuse_valid", 32'hFF);
    sb_expect("reuse_y", 32'd0);
    sb_expect("reuse_lanes", 32'hF);
    sb_expect("reuse_addr", 32'd9);
    @(negedge clk);
    sb_check(32'(slot_valid));
    sb_check(32'(slot_y[Y_W-1:0]));
    sb_check(32'(slot_lanes[3:0]));
    sb_check(32'(chart_addr));
    wait_for("done4", SEL_BUSY, 32'd0, 5000);
    check_eq("fill_miss_total", 32'(miss_count), 32'd36);

    // Two lanes of one slot pressed together
    rom[0] = {4'b0011, 8'd0};
    rom[1] = '0;
    pulse_start();
    base = hit_pulses;
    wait_for("y440", SEL_Y0, 32'd440, 2500);
    sb_expect("dual_hits", 32'd2);
    sb_expect("dual_valid", 32'd0);
    press(4'b0011);
    sb_check(32'(hit_count));
    sb_check(32'(slot_valid[0]));
    press(4'b0000);
    repeat (3) @(negedge clk);
    check_eq("dual_pulses", 32'(hit_pulses - base), 32'd1);
    wait_for("done5", SEL_BUSY, 32'd0, 20);
    check_eq("dual_miss", 32'(miss_count), 32'd0);

    // Reset while waiting on a long delay with three live slots
    for (int i = 0; i < 3; i++) rom[i] = {4'b0001, 8'd0};
    rom[3] = {4'b0001, 8'd200};
    rom[4] = '0;
    pulse_start();
    wait_for("three", SEL_VALID, 32'h07, 100);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 32'(slot_valid), 32'd0);
    check_eq("mid_rst_lanes", 32'(slot_lanes), 32'd0);
    check_eq("mid_rst_y", 32'(slot_y[31:0]), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_addr", 32'(chart_addr), 32'd0);
    check_eq("mid_rst_hits", 32'(hit_count), 32'd0);
    check_eq("mid_rst_miss", 32'(miss_count), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_valid", 32'(slot_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
Sequences the falling-note sprites of the rhythm game. It reads a note chart from an external synchronous ROM and allocates each note to one of N_SLOTS note slots. On a shared prescaled tick it advances every active slot's y position, and it retires slots that reach the screen bottom. It also judges player button presses against the hit line and keeps hit/miss counters. It sits between the chart ROM and the per-slot sprite renderers in top.

Parameters:
N_SLOTS, 8, number of concurrent note slots
TICK_DIV, 800000, CLOCK_24 cycles per movement tick
Y_W, 9, y coordinate width
Y_SPAWN, 0, initial y of a spawned note
Y_HIT, 440, hit-line y
HIT_WIN, 8, hit tolerance; a press is accepted when |y - Y_HIT| <= HIT_WIN
Y_END, 480, a slot whose y reaches this value is retired
ADDR_W, 6, chart ROM address width

Ports:
CLOCK_24  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  single-cycle pulse; begins chart playback from address 0
chart_addr  out  ADDR_W  chart ROM address
chart_data  in  12  {lane_mask[11:8], delay[7:0]}; valid one cycle after chart_addr
buttons  in  4  lane buttons, already synchronised, level
slot_valid  out  N_SLOTS  slot i is active
slot_lanes  out  4*N_SLOTS  remaining unhit lane mask of slot i (command_out for the sprite)
slot_y  out  Y_W*N_SLOTS  y position of slot i
hit_count  out  16  saturating count of hit lanes
miss_count  out  16  saturating count of missed lanes
hit_pulse  out  1  one-cycle pulse on any hit
miss_pulse  out  1  one-cycle pulse on any miss
busy  out  1  high from start until DONE

Behaviour:
- Reset (and a reset asserted mid-operation):
  - All outputs go to 0, FSM goes to IDLE, prescaler clears to 0.
  - Previous-button register clears to 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and runs only while busy.
  - tick is asserted in the cycle where count == TICK_DIV-1.
- FSM states:
  - IDLE: start -> FETCH with chart_addr=0, counters cleared, busy=1.
  - FETCH: one cycle for ROM latency, then -> LOAD.
  - LOAD: latch the chart_data fields.
    - lane_mask==0 and delay==0 is the end marker -> DRAIN.
    - Otherwise load the delay counter with delay -> WAIT.
  - WAIT: the delay counter decrements on each tick.
    - When the counter is 0 (including delay==0 on entry) -> SPAWN.
  - SPAWN: pick the lowest-index slot with slot_valid==0, using the free mask at the start of the cycle.
    - That slot gets valid=1, lanes=lane_mask, y=Y_SPAWN; chart_addr+1; -> FETCH.
    - lane_mask==0 with delay!=0 is a rest entry: nothing is spawned, but chart_addr still increments.
    - No free slot: stay in SPAWN (stall) until a slot frees.
  - DRAIN: when all slot_valid==0 -> DONE.
  - DONE: busy=0; start restarts playback (-> FETCH, addr 0, counters cleared).
  - chart_addr wraps modulo 2^ADDR_W.
- Movement: on tick, every valid slot does y <= y+1.
  - If y+1 == Y_END the slot is retired: valid=0, lanes=0.
  - On retirement, miss_count += popcount(remaining lanes) and miss_pulse=1 when that popcount > 0.
- Judging:
  - A press is a rising edge on buttons[k], compared against a registered copy of buttons.
  - For each pressed lane k, take the lowest-index valid slot with lanes[k]=1 and y inside the window. Clear lanes[k] in that slot, hit_count += 1, hit_pulse=1.
  - If a slot's lanes become 0, the slot is retired (valid=0) with no miss.
  - A press with no qualifying slot has no effect.
- Simultaneous events:
  - Judging uses the pre-tick y.
  - A hit and a retirement of the same slot in the same cycle: the hit is applied first, and only the remaining lanes count as misses.
  - Several lanes pressed in one cycle are all judged in that cycle.
  - A slot freed this cycle can be spawned into next cycle at the earliest.
- Counters saturate at 16'hFFFF.
- hit_pulse and miss_pulse are registered, with 1-cycle latency.

Decomposition:
- Shared package note_pkg: the FSM state encoding, lane count LANES=4, the chart-word field positions, and the end-marker constant.
- One natural sub-module, note_slot: holds one slot's valid/lanes/y, applies the tick and the lane-clear mask, and flags retirement. note_scheduler instantiates it N_SLOTS times and keeps the FSM, prescaler, allocator priority encoder and judge.

Test Plan:
Use TICK_DIV=4 for simulation.
- Chart {4'b0001,8'd2},{0,0}; start -> spawn in slot 0 after 2 ticks, y=0, lanes=0001, chart_addr=1; after 480 further ticks slot 0 retires, miss_count=1, miss_pulse once, then DONE with busy=0.
- Same chart; press buttons[0] when slot 0 y=435 -> hit_count=1, slot 0 retires immediately, miss_count=0; a repeat press has no effect.
- Press when y=431 (outside window), then again at y=432 -> first press ignored, second press hits.
- Chart of 9 entries {4'b1111,0} -> slots 0-7 fill; FSM stalls in SPAWN with chart_addr=8 until slot 0 retires at y=480, then the 9th note lands in slot 0.
- Slot with lanes=0011 at y=440, buttons 0 and 1 rise in the same cycle -> hit_count+=2, slot retires, single hit_pulse.
- Assert reset while in WAIT with 3 active slots -> next cycle all slot outputs 0, counters 0, IDLE, busy=0.
